// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states, op decode helpers.
// MULT_DIV_MADD_EN enables the MADD/MADDU accumulate ops (encodings 6/7).
package mult_div_unit_pkg;

  localparam int unsigned MD_XLEN = 32;
  localparam int unsigned MD_ITER = 32;
  localparam int unsigned MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_OP_MULT  = 3'd0,
    MD_OP_MULTU = 3'd1,
    MD_OP_DIV   = 3'd2,
    MD_OP_DIVU  = 3'd3,
    MD_OP_MTHI  = 3'd4,
    MD_OP_MTLO  = 3'd5,
    MD_OP_MADD  = 3'd6,
    MD_OP_MADDU = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } md_state_e;

  function automatic logic md_is_mul(input logic [MD_OP_W-1:0] op);
`ifdef MULT_DIV_MADD_EN
    return op inside {MD_OP_MULT, MD_OP_MULTU, MD_OP_MADD, MD_OP_MADDU};
`else
    return op inside {MD_OP_MULT, MD_OP_MULTU};
`endif
  endfunction

  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return op inside {MD_OP_DIV, MD_OP_DIVU};
  endfunction

  function automatic logic md_is_signed(input logic [MD_OP_W-1:0] op);
`ifdef MULT_DIV_MADD_EN
    return op inside {MD_OP_MULT, MD_OP_DIV, MD_OP_MADD};
`else
    return op inside {MD_OP_MULT, MD_OP_DIV};
`endif
  endfunction

`ifdef MULT_DIV_MADD_EN
  function automatic logic md_is_madd(input logic [MD_OP_W-1:0] op);
    return op inside {MD_OP_MADD, MD_OP_MADDU};
  endfunction
`endif

endpackage

// File: rtl/mult_div_unit_md_shift_core.sv
// Iterative datapath: 64-bit working register and iteration counter; radix-2 shift/add multiply
// (multiplier in the low half) or restoring divide (remainder high, quotient low), one bit per step.
module md_shift_core #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] result,
  output logic              last
);

  localparam int unsigned CW = $clog2(ITER);

  logic [2*XLEN-1:0] work;
  logic [2*XLEN-1:0] work_next;
  logic [XLEN-1:0]   opnd;
  logic [CW-1:0]     count;
  logic [XLEN:0]     mul_sum;
  logic              div_ge;
  logic [XLEN-1:0]   rem_sub;

  // The divide step examines the remainder as it would look after the left shift,
  // so the shift and trial subtraction happen in the same cycle.
  always_comb begin
    mul_sum   = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, opnd} : '0);
    div_ge    = work[2*XLEN-1:XLEN-1] >= {1'b0, opnd};
    rem_sub   = work[2*XLEN-2:XLEN-1] - opnd;
    work_next = work;
    if (is_div) begin
      if (div_ge) work_next = {rem_sub, work[XLEN-2:0], 1'b1};
      else        work_next = {work[2*XLEN-2:0], 1'b0};
    end else begin
      work_next = {mul_sum, work[XLEN-1:1]};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      work  <= '0;
      opnd  <= '0;
      count <= '0;
    end else if (load) begin
      work  <= {{XLEN{1'b0}}, a};
      opnd  <= b;
      count <= '0;
    end else if (step) begin
      work  <= work_next;
      count <= count + 1'b1;
    end
  end

  assign result = work;
  assign last   = (count == CW'(ITER - 1));

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: FSM, op decode, sign capture/fixup and the architectural HI/LO registers.
// Build option MULT_DIV_MADD_EN adds MADD/MADDU (accumulate the product into {hi,lo}).
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned XLEN = MD_XLEN,
  parameter int unsigned ITER = MD_ITER
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic [XLEN-1:0]    rsData,
  input  logic [XLEN-1:0]    rtData,
  input  logic               cancel,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    hi,
  output logic [XLEN-1:0]    lo
);

  md_state_e         state, state_next;
  logic              idle_req;
  logic              go;
  logic              op_signed;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic              step;
  logic              finish_write;
  logic              core_last;
  logic [2*XLEN-1:0] core_result;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic [2*XLEN-1:0] hilo_next;

  logic              is_div_q;
  logic              neg_res_q;
  logic              neg_rem_q;
  logic              div_zero_q;
  logic [XLEN-1:0]   rs_q;
`ifdef MULT_DIV_MADD_EN
  logic              madd_q;
`endif

  always_comb begin
    idle_req  = (state == ST_IDLE) && start && !cancel;
    go        = idle_req && (md_is_mul(op) || md_is_div(op));
    op_signed = md_is_signed(op);
    a_abs     = (op_signed && rsData[XLEN-1]) ? -rsData : rsData;
    b_abs     = (op_signed && rtData[XLEN-1]) ? -rtData : rtData;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (go) state_next = ST_RUN;
      ST_RUN:    if (cancel) state_next = ST_IDLE;
                 else if (core_last) state_next = ST_FINISH;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign step         = (state == ST_RUN) && !cancel;
  assign finish_write = (state == ST_FINISH) && !cancel;
  assign busy         = (state != ST_IDLE);

  md_shift_core #(
    .XLEN(XLEN),
    .ITER(ITER)
  ) u_core (
    .clock  (clock),
    .reset_n(reset_n),
    .load   (go),
    .step   (step),
    .is_div (is_div_q),
    .a      (a_abs),
    .b      (b_abs),
    .result (core_result),
    .last   (core_last)
  );

  // Magnitudes are computed unsigned; signs recorded at capture are reapplied here.
  always_comb begin
    prod      = neg_res_q ? -core_result : core_result;
    quo       = neg_res_q ? -core_result[XLEN-1:0] : core_result[XLEN-1:0];
    rem       = neg_rem_q ? -core_result[2*XLEN-1:XLEN] : core_result[2*XLEN-1:XLEN];
    hilo_next = prod;
    if (is_div_q) begin
      if (div_zero_q) hilo_next = {rs_q, {XLEN{1'b1}}};
      else            hilo_next = {rem, quo};
    end
`ifdef MULT_DIV_MADD_EN
    else if (madd_q) begin
      hilo_next = {hi, lo} + prod;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      hi         <= '0;
      lo         <= '0;
      done       <= 1'b0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      rs_q       <= '0;
`ifdef MULT_DIV_MADD_EN
      madd_q     <= 1'b0;
`endif
    end else begin
      state <= state_next;
      done  <= finish_write;
      if (go) begin
        is_div_q   <= md_is_div(op);
        neg_res_q  <= op_signed && (rsData[XLEN-1] ^ rtData[XLEN-1]);
        neg_rem_q  <= op_signed && rsData[XLEN-1];
        div_zero_q <= (rtData == '0);
        rs_q       <= rsData;
`ifdef MULT_DIV_MADD_EN
        madd_q     <= md_is_madd(op);
`endif
      end
      if (finish_write) begin
        {hi, lo} <= hilo_next;
      end else if (idle_req && op == MD_OP_MTHI) begin
        hi <= rsData;
      end else if (idle_req && op == MD_OP_MTLO) begin
        lo <= rsData;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus random ops checked against an
// arithmetic reference model of HI/LO. Honours MULT_DIV_MADD_EN when defined.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rsData = '0;
  logic [31:0] rtData = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mult_div_unit dut (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .rsData (rsData),
    .rtData (rtData),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on the operands, returns {hi, lo}.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] h, input logic [31:0] l);
    longint sp;
    int     q, r;
    case (o)
      3'd0: begin sp = longint'(int'(a)) * longint'(int'(b)); return 64'(sp); end
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        return {r, q};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd4: return {a, l};
      3'd5: return {h, a};
`ifdef MULT_DIV_MADD_EN
      3'd6: begin sp = longint'(int'(a)) * longint'(int'(b)); return {h, l} + 64'(sp); end
      3'd7: return {h, l} + {32'd0, a} * {32'd0, b};
`endif
      default: return {h, l};
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'(int'($urandom_range(0, 20)) - 10);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op and check timing and HI/LO; poke re-requests start while busy.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit poke);
    logic [63:0] e;
    int          n;
    bit          long_op;
    bit          saw_done;
    e = model(o, a, b, exp_hi, exp_lo);
    long_op = (o <= 3'd3);
`ifdef MULT_DIV_MADD_EN
    if (o >= 3'd6) long_op = 1'b1;
`endif
    @(negedge clock);
    start = 1'b1; op = o; rsData = a; rtData = b;
    @(negedge clock);
    start = 1'b0; rsData = $urandom; rtData = $urandom;
    if (long_op) begin
      n = 0;
      saw_done = 1'b0;
      while (busy && n < 100) begin
        if (done) saw_done = 1'b1;
        if (poke && n == 5) begin
          start = 1'b1; op = 3'd4; rsData = $urandom;
        end else begin
          start = 1'b0;
        end
        n++;
        @(negedge clock);
      end
      start = 1'b0;
      check("busy_cycles", 64'(n), 64'd33);
      check("done_while_busy", 64'(saw_done), 64'd0);
      check("done_pulse", 64'(done), 64'd1);
    end else begin
      check("busy_short_op", 64'(busy), 64'd0);
      check("done_short_op", 64'(done), 64'd0);
    end
    check("hi", 64'(hi), 64'(e[63:32]));
    check("lo", 64'(lo), 64'(e[31:0]));
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    @(negedge clock);
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  // Start MULTU then abort in its 10th busy cycle by cancel or by reset.
  task automatic abort_op(input bit use_reset);
    bit saw_done;
    @(negedge clock);
    start = 1'b1; op = 3'd1; rsData = $urandom; rtData = $urandom;
    @(negedge clock);
    start = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clock);
    check("busy_before_abort", 64'(busy), 64'd1);
    if (use_reset) reset_n = 1'b0; else cancel = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    cancel = 1'b0;
    check("busy_after_abort", 64'(busy), 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) saw_done = 1'b1;
      @(negedge clock);
    end
    check("no_done_after_abort", 64'(saw_done), 64'd0);
    if (use_reset) begin
      exp_hi = '0;
      exp_lo = '0;
    end
    check("hi_after_abort", 64'(hi), 64'(exp_hi));
    check("lo_after_abort", 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    reset_n = 1'b1;

    do_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    do_op(3'd3, 32'd100, 32'd7, 1'b0);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(3'd2, 32'h1234_5678, 32'd0, 1'b0);
    do_op(3'd3, 32'hCAFE_0001, 32'd0, 1'b0);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    do_op(3'd5, 32'h0BAD_F00D, 32'd0, 1'b0);

    // cancel and start together in IDLE: nothing captured
    @(negedge clock);
    start = 1'b1; cancel = 1'b1; op = 3'd4; rsData = 32'h1111_2222;
    @(negedge clock);
    start = 1'b0; cancel = 1'b0;
    check("cancel_start_busy", 64'(busy), 64'd0);
    check("cancel_start_hi", 64'(hi), 64'(exp_hi));

    abort_op(1'b0);
    abort_op(1'b1);

`ifdef MULT_DIV_MADD_EN
    do_op(3'd5, 32'd5, 32'd0, 1'b0);
    do_op(3'd4, 32'd0, 32'd0, 1'b0);
    do_op(3'd7, 32'd3, 32'd4, 1'b0);
    do_op(3'd4, 32'd1, 32'd0, 1'b0);
    do_op(3'd5, 32'd2, 32'd0, 1'b0);
    do_op(3'd6, 32'd2, 32'hFFFF_FFFD, 1'b0);
`else
    do_op(3'd6, 32'd2, 32'd3, 1'b0);
    do_op(3'd7, 32'd2, 32'd3, 1'b0);
`endif

    for (int i = 0; i < 30; i++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick(), ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the rs/rt operand values the register file produces.
- Owns the architectural HI and LO registers, which the pipeline reads for MFHI/MFLO.
- Radix-2 shift/add multiply and restoring divide, one bit per cycle; the pipeline stalls on `busy`.

Parameters:
- XLEN, 32, operand width; HI/LO width.
- ITER, 32, iterations per operation; must equal XLEN.

Ports:
- clock  input  1  single clock, rising edge
- reset_n  input  1  synchronous, active-low reset
- start  input  1  operation request; sampled only in IDLE
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
- rsData  input  32  operand A from register file rsOut (dividend / multiplicand / MTHI-MTLO source)
- rtData  input  32  operand B from register file rtOut (divisor / multiplier)
- cancel  input  1  pipeline flush; aborts the in-flight operation
- busy  output  1  high while an operation is in RUN or FINISH
- done  output  1  one-cycle pulse; HI/LO hold the new result during this cycle
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (reset_n low at a clock edge): state IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0. Reset mid-operation aborts it with no done pulse. Reset has priority over every other input.
- States: IDLE, RUN, FINISH.
- IDLE, start=1, cancel=0, op in 0..3:
  - Capture operands.
  - Signed ops (MULT, DIV) capture absolute values and record the result signs.
  - State goes to RUN with count=0; busy=1 from the next cycle.
- IDLE, start=1, op 4/5: hi (MTHI) or lo (MTLO) takes rsData at that edge. Stay IDLE; busy stays 0; no done pulse.
- IDLE, start=1, op 6/7: ignored (see Optional Feature).
- RUN: one iteration per edge; after the 32nd iteration (count=31) the state goes to FINISH.
  - Multiply: 64-bit product register; add the multiplicand when the LSB is set, then shift right.
  - Divide: shift the remainder/quotient pair left, subtract the divisor, restore if negative.
- FINISH, at the next edge:
  - Sign-correct the result and write HI/LO: mult HI = upper 32 bits, LO = lower 32 bits; div LO = quotient, HI = remainder.
  - Return to IDLE; done=1 for exactly one cycle; busy=0 in that same cycle.
- Latency: start edge E0 -> done high and new hi/lo visible in the cycle after E33. busy is high for exactly 33 cycles.
- Sign rules:
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Signed product is negated iff the operand signs differ (64-bit two's complement).
- Divide by zero, signed or unsigned: LO=0xFFFFFFFF, HI=rsData. Still takes the full 33 cycles.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- start while busy: ignored; no queueing.
- cancel in RUN or FINISH: return to IDLE at that edge; hi/lo unchanged; no done pulse.
- cancel and start together in IDLE: cancel wins; nothing is captured.
- rsData/rtData only need to be valid at the start edge.

Optional Feature:
- Macro: MULT_DIV_MADD_EN.
- Defined: op 6 = MADD, op 7 = MADDU.
  - Run the signed/unsigned multiply as usual.
  - In FINISH, {hi,lo} <= {hi,lo} + product (64-bit wrap-around; no carry out).
  - Uses the HI/LO values present at the FINISH edge.
  - Same 33-cycle latency.
- Undefined: ops 6/7 are ignored in IDLE, like other reserved encodings, and no accumulate adder is built.

Decomposition:
- Shared include mult_div.vh, next to control.vh, holds:
  - op encoding defines (MD_OP_MULT .. MD_OP_MADDU)
  - the op field width
  - MD_ITER
  - FSM state encodings
- Natural sub-module: md_shift_core.
  - Holds the 64-bit working register, counter, and the per-iteration add/subtract-and-shift.
  - The top level keeps the FSM, sign capture/fixup, HI/LO registers and the op decode.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=0x00000003 -> done 33 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high for exactly 33 cycles.
- DIVU rs=100, rt=7 -> lo=14, hi=2. DIV rs=-7 (0xFFFFFFF9), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV rs=0x12345678, rt=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI rs=0xDEADBEEF, then MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. A second start issued while busy is ignored.
- Start MULTU, assert cancel in cycle 10 -> busy drops, no done pulse, hi/lo keep their prior values. Same scenario with reset_n low mid-RUN -> hi=lo=0, no done pulse.
- With MULT_DIV_MADD_EN: MTLO 5, MTHI 0, then MADDU 3*4 -> hi=0, lo=17. MADD with a negative product crosses the boundary: lo wraps and hi decrements.
